// File: rtl/ernic_tx_path_generator.sv
// Transmit-side stimulus for the ERNIC example design: posts SQ doorbells for one QP,
// serves incremental-pattern payload bursts as an AXI4 read slave, and tracks send completions.
module ernic_tx_path_generator #(
    parameter int unsigned C_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned NUM_WQE               = 8,
    parameter logic [3:0]  PATTERN_NIBBLE        = 4'h0,
    parameter logic [31:0] SQ_PIDB_BASE          = 32'h50040238
) (
    input  logic                             core_clk,
    input  logic                             core_rst_n,
    input  logic                             start,
    input  logic [2:0]                       qp_num,
    input  logic [C_AXI_THREAD_ID_WIDTH-1:0] data_s_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]      data_s_axi_araddr,
    input  logic [7:0]                       data_s_axi_arlen,
    input  logic [1:0]                       data_s_axi_arburst,
    input  logic                             data_s_axi_arvalid,
    output logic                             data_s_axi_arready,
    output logic [C_AXI_THREAD_ID_WIDTH-1:0] data_s_axi_rid,
    output logic [511:0]                     data_s_axi_rdata,
    output logic [1:0]                       data_s_axi_rresp,
    output logic                             data_s_axi_rlast,
    output logic                             data_s_axi_rvalid,
    input  logic                             data_s_axi_rready,
    output logic [15:0]                      qp_sq_pidb_hndshk,
    output logic [31:0]                      qp_sq_pidb_wr_addr_hndshk,
    output logic                             qp_sq_pidb_wr_valid_hndshk,
    input  logic                             qp_sq_pidb_wr_rdy,
    input  logic                             resp_hndler_o_send_cq_db_cnt_valid,
    output logic                             tx_busy,
    output logic                             tx_done
);

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;
    typedef enum logic [1:0] {DB_IDLE, DB_ISSUE, DB_WAIT_RD, DB_WAIT_CQ} db_state_e;

    localparam logic [15:0] NUM_WQE_PIDB = 16'(NUM_WQE);
    localparam logic [7:0]  NUM_WQE_CQ   = 8'(NUM_WQE);

    // Payload content does not depend on the read address.
    logic unused_araddr;
    assign unused_araddr = ^data_s_axi_araddr;

    // ---------------- read slave ----------------
    rd_state_e                        rd_state_q, rd_state_d;
    logic                             arready_q, arready_d;
    logic [C_AXI_THREAD_ID_WIDTH-1:0] rid_q, rid_d;
    logic [7:0]                       arlen_q, arlen_d;
    logic [7:0]                       beat_q, beat_d;
    logic [1:0]                       arburst_q, arburst_d;
    logic [3:0]                       burst_cnt_q, burst_cnt_d;
    logic                             rvalid, rlast, rd_burst_done;

    assign rvalid        = (rd_state_q == RD_BURST);
    assign rlast         = rvalid && (beat_q == arlen_q);
    assign rd_burst_done = rvalid && data_s_axi_rready && rlast;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rd_state_q  <= RD_IDLE;
            arready_q   <= 1'b0;
            rid_q       <= '0;
            arlen_q     <= '0;
            beat_q      <= '0;
            arburst_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            arready_q   <= arready_d;
            rid_q       <= rid_d;
            arlen_q     <= arlen_d;
            beat_q      <= beat_d;
            arburst_q   <= arburst_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        arready_d   = arready_q;
        rid_d       = rid_q;
        arlen_d     = arlen_q;
        beat_d      = beat_q;
        arburst_d   = arburst_q;
        burst_cnt_d = burst_cnt_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (data_s_axi_arvalid && arready_q) begin
                    rid_d       = data_s_axi_arid;
                    arlen_d     = data_s_axi_arlen;
                    arburst_d   = data_s_axi_arburst;
                    beat_d      = '0;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    arready_d   = 1'b0;
                    rd_state_d  = RD_BURST;
                end
            end
            RD_BURST: begin
                if (data_s_axi_rready) begin
                    if (rlast) begin
                        arready_d  = 1'b1;
                        rd_state_d = RD_IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign data_s_axi_arready = arready_q;
    assign data_s_axi_rvalid  = rvalid;
    assign data_s_axi_rlast   = rlast;
    assign data_s_axi_rid     = rvalid ? rid_q : '0;
    assign data_s_axi_rdata   = rvalid ? {64{{PATTERN_NIBBLE, burst_cnt_q}}} : '0;
    assign data_s_axi_rresp   = (rvalid && (arburst_q != 2'b01)) ? 2'b10 : 2'b00;

    // ---------------- doorbell sequencer ----------------
    db_state_e   db_state_q, db_state_d;
    logic [2:0]  qp_q, qp_d;
    logic [15:0] pidb_q, pidb_d;
    logic [7:0]  cq_cnt_q, cq_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        db_valid;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            db_state_q <= DB_IDLE;
            qp_q       <= '0;
            pidb_q     <= '0;
            cq_cnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            db_state_q <= db_state_d;
            qp_q       <= qp_d;
            pidb_q     <= pidb_d;
            cq_cnt_q   <= cq_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        db_state_d = db_state_q;
        qp_d       = qp_q;
        pidb_d     = pidb_q;
        cq_cnt_d   = cq_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        // Completions count in every busy state, including the cycle that ends the run.
        if (busy_q && resp_hndler_o_send_cq_db_cnt_valid && (cq_cnt_q != 8'hFF))
            cq_cnt_d = cq_cnt_q + 8'd1;
        case (db_state_q)
            DB_IDLE: begin
                if (start) begin
                    qp_d       = qp_num;
                    pidb_d     = '0;
                    cq_cnt_d   = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    db_state_d = DB_ISSUE;
                end
            end
            DB_ISSUE: begin
                if (qp_sq_pidb_wr_rdy) begin
                    pidb_d     = pidb_q + 16'd1;
                    db_state_d = DB_WAIT_RD;
                end
            end
            DB_WAIT_RD: begin
                if (rd_burst_done)
                    db_state_d = (pidb_q == NUM_WQE_PIDB) ? DB_WAIT_CQ : DB_ISSUE;
            end
            DB_WAIT_CQ: begin
                if (cq_cnt_q == NUM_WQE_CQ) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    db_state_d = DB_IDLE;
                end
            end
            default: db_state_d = DB_IDLE;
        endcase
    end

    assign db_valid                   = (db_state_q == DB_ISSUE);
    assign qp_sq_pidb_wr_valid_hndshk = db_valid;
    assign qp_sq_pidb_wr_addr_hndshk  = db_valid ? (SQ_PIDB_BASE + 32'({qp_q, 8'h00})) : '0;
    assign qp_sq_pidb_hndshk          = db_valid ? (pidb_q + 16'd1) : '0;
    assign tx_busy                    = busy_q;
    assign tx_done                    = done_q;

endmodule
